// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   Conditions one raw, asynchronous, bouncing push-button pin for user logic.
//   The pin passes through a 2-flop synchroniser, is debounced by a
//   stable-time counter inside a four-state FSM, and is presented as a clean
//   level plus registered one-cycle press / release pulses.
//
//   Optional feature macro: LONG_PRESS_EN
//     defined   -> a hold counter produces one long_press_o pulse after the
//                  debounced button has been held for 2^LONG_WIDTH cycles.
//     undefined -> long_press_o is driven constant 0 (port list unchanged).
//
//   Timing for a clean step on btn_in_i: the pulse is high in the cycle after
//   the (2^CNT_WIDTH + 3)-th rising edge following the change
//   (2 synchroniser edges + 1 entry edge + 2^CNT_WIDTH counting edges).
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int CNT_WIDTH  = 14,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_WIDTH = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_in_i,
  output logic btn_state_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  // Counter widths below 2 make the max/increment constants degenerate.
  if (CNT_WIDTH < 2 || LONG_WIDTH < 2) begin : g_param_check
    $error("button_debounce: CNT_WIDTH and LONG_WIDTH must both be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // Pin level that means "not pressed"; also the synchroniser reset value so
  // that reset never looks like a press edge.
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic                 sync1_q;
  logic                 sync2_q;
  logic                 pressed_s;

  state_e               state_q;
  state_e               state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  logic                 btn_state_q;
  logic                 btn_state_d;
  logic                 press_q;
  logic                 press_d;
  logic                 release_q;
  logic                 release_d;

  // ---------------------------------------------------------------------------
  // Synchroniser: the only flops allowed to go metastable. Nothing else
  // looks at btn_in_i directly.
  // ---------------------------------------------------------------------------

  // Two-stage synchroniser, reset to the idle pin level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= btn_in_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity: 1 means the button is physically pressed.
  assign pressed_s = sync2_q ^ IDLE_LVL;

  // ---------------------------------------------------------------------------
  // Debounce FSM
  //   A WAIT state is entered on the first sample that disagrees with the
  //   debounced level; any agreeing sample aborts back to the stable state, so
  //   a reversal always restarts the full interval. The transition taken at
  //   cnt == max preempts the increment, so the counter never wraps.
  // ---------------------------------------------------------------------------

  // Next-state, counter and registered-output logic for the debounce FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    btn_state_d = btn_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        if (pressed_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_RELEASED;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_PRESS_WAIT: begin
        if (!pressed_s) begin
          // Bounce rejected: silently fall back, no pulse.
          state_d = ST_RELEASED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d     = ST_PRESSED;
          cnt_d       = CNT_ZERO;
          btn_state_d = 1'b1;
          press_d     = 1'b1;
        end
      end

      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_PRESSED;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_RELEASE_WAIT: begin
        if (pressed_s) begin
          // Release bounce: still the same press, no pulse.
          state_d = ST_PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d     = ST_RELEASED;
          cnt_d       = CNT_ZERO;
          btn_state_d = 1'b0;
          release_d   = 1'b1;
        end
      end

      default: begin
        // Unreachable with a 2-bit encoding; recover to the safe idle state.
        state_d     = ST_RELEASED;
        cnt_d       = CNT_ZERO;
        btn_state_d = 1'b0;
      end
    endcase
  end

  // FSM state, debounce counter and registered level/pulse outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RELEASED;
      cnt_q       <= CNT_ZERO;
      btn_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_state_q <= btn_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign btn_state_o = btn_state_q;
  assign press_o     = press_q;
  assign release_o   = release_q;

  // ---------------------------------------------------------------------------
  // Long-press detector
  //   The hold counter restarts only on a debounced press (PRESS_WAIT ->
  //   PRESSED). A release bounce (RELEASE_WAIT -> PRESSED) keeps counting, so
  //   a noisy hold still yields exactly one pulse. A sticky flag suppresses
  //   auto-repeat while the counter sits at max.
  // ---------------------------------------------------------------------------
`ifdef LONG_PRESS_EN

  localparam logic [LONG_WIDTH-1:0] LCNT_ZERO = {LONG_WIDTH{1'b0}};
  localparam logic [LONG_WIDTH-1:0] LCNT_ONE  = {{(LONG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LONG_WIDTH-1:0] LCNT_MAX  = {LONG_WIDTH{1'b1}};

  logic                  enter_pressed_s;
  logic                  held_s;
  logic [LONG_WIDTH-1:0] lcnt_q;
  logic [LONG_WIDTH-1:0] lcnt_d;
  logic                  lfired_q;
  logic                  lfired_d;
  logic                  long_press_q;
  logic                  long_press_d;

  assign enter_pressed_s = (state_q == ST_PRESS_WAIT) && pressed_s && (cnt_q == CNT_MAX);
  assign held_s          = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

  // Hold counter and one-shot long-press pulse generation.
  always_comb begin
    lcnt_d       = lcnt_q;
    lfired_d     = lfired_q;
    long_press_d = 1'b0;

    if (enter_pressed_s) begin
      // Cycle of the press pulse: restart timing, never pulse here.
      lcnt_d   = LCNT_ZERO;
      lfired_d = 1'b0;
    end else if (held_s) begin
      if (lcnt_q != LCNT_MAX) begin
        lcnt_d = lcnt_q + LCNT_ONE;
      end else if (!lfired_q) begin
        long_press_d = 1'b1;
        lfired_d     = 1'b1;
      end else begin
        lcnt_d = lcnt_q;
      end
    end else begin
      lcnt_d   = LCNT_ZERO;
      lfired_d = 1'b0;
    end
  end

  // Hold counter, fired flag and long-press output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lcnt_q       <= LCNT_ZERO;
      lfired_q     <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      lcnt_q       <= lcnt_d;
      lfired_q     <= lfired_d;
      long_press_q <= long_press_d;
    end
  end

  assign long_press_o = long_press_q;

`else

  assign long_press_o = 1'b0;

`endif

endmodule
